mtime_timer: RTL and testbench

MTIME_TIMER -- requirements
Module: mtime_timer

---
 rtl/mtime_timer.sv | 137 +++++++++++++
 tb/tb_mtime_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mtime_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare register and
// registered interrupt level; MTIME_HI reads return the half latched by the last MTIME_LO read.
module mtime_timer #(
  parameter logic [31:0] BASE_ADDR      = 32'hC000_0000,
  parameter logic [15:0] PRESCALE_RESET = 16'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strobe,
  output logic [31:0] rd_data,
  output logic        access_fault,
  output logic        mtime_interrupt
);

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_CTRL        = 3'd4;
  localparam logic [2:0] REG_PRESCALE    = 3'd5;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic [15:0] prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [31:0] shadow_q, shadow_d;
  logic        irq_q, irq_d;

  logic        sel, bad_off, rd_ok, wr_ok;
  logic [2:0]  reg_idx;
  logic [31:0] wr_mask;

  assign sel     = (addr[31:5] == BASE_ADDR[31:5]);
  assign reg_idx = addr[4:2];
  assign bad_off = (addr[1:0] != 2'b00) || (reg_idx == 3'd6) || (reg_idx == 3'd7);

  assign access_fault = rst_n & (rd_en | wr_en) & sel & bad_off;
  assign rd_ok        = rst_n & rd_en & sel & ~bad_off;
  assign wr_ok        = wr_en & sel & ~bad_off;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask
      assign wr_mask[8*gi +: 8] = {8{wr_strobe[gi]}};
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      case (reg_idx)
        REG_MTIME_LO:    rd_data = mtime_q[31:0];
        REG_MTIME_HI:    rd_data = shadow_q;
        REG_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
        REG_CTRL:        rd_data = {31'd0, en_q};
        REG_PRESCALE:    rd_data = {16'd0, prescale_q};
        default:         rd_data = '0;
      endcase
    end
  end

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    shadow_d   = shadow_q;
    irq_d      = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d  = 16'd0;
        mtime_d = mtime_q + 64'd1;
      end else begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end

    // Snapshot the high half so a following MTIME_HI read is coherent with this LO.
    if (rd_ok && reg_idx == REG_MTIME_LO)
      shadow_d = mtime_q[63:32];

    if (wr_ok) begin
      case (reg_idx)
        REG_MTIME_LO: begin
          mtime_d = {mtime_q[63:32], (mtime_q[31:0] & ~wr_mask) | (wr_data & wr_mask)};
          pcnt_d  = 16'd0;
        end
        REG_MTIME_HI: begin
          mtime_d = {(mtime_q[63:32] & ~wr_mask) | (wr_data & wr_mask), mtime_q[31:0]};
          pcnt_d  = 16'd0;
        end
        REG_MTIMECMP_LO:
          mtimecmp_d[31:0] = (mtimecmp_q[31:0] & ~wr_mask) | (wr_data & wr_mask);
        REG_MTIMECMP_HI:
          mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wr_mask) | (wr_data & wr_mask);
        REG_CTRL:
          if (wr_strobe[0]) en_d = wr_data[0];
        REG_PRESCALE: begin
          prescale_d = (prescale_q & ~wr_mask[15:0]) | (wr_data[15:0] & wr_mask[15:0]);
          pcnt_d     = 16'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b1;
      prescale_q <= PRESCALE_RESET;
      pcnt_q     <= 16'd0;
      shadow_q   <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      shadow_q   <= shadow_d;
      irq_q      <= irq_d;
    end
  end

  assign mtime_interrupt = irq_q;

endmodule

// File: tb/tb_mtime_timer.sv
// Directed bench for mtime_timer: register table plus hand-built sequences for
// prescaled counting, atomic 64-bit reads, compare interrupt, strobed writes and async reset.
module tb_mtime_timer;
  localparam logic [31:0] B = 32'hC000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strobe = '0;
  logic [31:0] rd_data;
  logic        access_fault;
  logic        mtime_interrupt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  mtime_timer #(.BASE_ADDR(B), .PRESCALE_RESET(16'd3)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
    .access_fault(access_fault), .mtime_interrupt(mtime_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rdat, output logic f);
    @(negedge clk);
    rd_en = r; wr_en = w; addr = a; wr_data = d; wr_strobe = s;
    #1;
    rdat = rd_data;
    f    = access_fault;
    $display("txn rd=%0b wr=%0b addr=%h wdata=%h strb=%b -> rdata=%h fault=%0b irq=%0b",
             r, w, a, d, s, rdat, f, mtime_interrupt);
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; wr_strobe = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic f;
    bus(1'b0, 1'b1, a, d, s, r, f);
    chk("wr_no_fault", {31'd0, f}, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic f;
    bus(1'b1, 1'b0, a, 32'd0, 4'd0, r, f);
    chk(name, r, exp);
  endtask

  task automatic idle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic [31:0] er,
                     input logic ef);
    vec_t v;
    v.name = n; v.rd = r; v.wr = w; v.a = a; v.d = d; v.s = s; v.exp_rd = er; v.exp_fault = ef;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] r;
    logic f;

    // Register table, run with EN cleared so nothing moves underneath it.
    add("ctrl_disable",   0, 1, B+32'h10, 32'h0,          4'h1, 32'h0,          0);
    add("mlo_write",      0, 1, B+32'h00, 32'h1122_3344,  4'hF, 32'h0,          0);
    add("mhi_write",      0, 1, B+32'h04, 32'h5566_7788,  4'hF, 32'h0,          0);
    add("mlo_read",       1, 0, B+32'h00, 32'h0,          4'h0, 32'h1122_3344,  0);
    add("mhi_read",       1, 0, B+32'h04, 32'h0,          4'h0, 32'h5566_7788,  0);
    add("cmplo_strb_wr",  0, 1, B+32'h08, 32'hAABB_CCDD,  4'h5, 32'h0,          0);
    add("cmplo_read",     1, 0, B+32'h08, 32'h0,          4'h0, 32'hFFBB_FFDD,  0);
    add("cmphi_read",     1, 0, B+32'h0C, 32'h0,          4'h0, 32'hFFFF_FFFF,  0);
    add("presc_write",    0, 1, B+32'h14, 32'hDEAD_1234,  4'hF, 32'h0,          0);
    add("presc_read",     1, 0, B+32'h14, 32'h0,          4'h0, 32'h0000_1234,  0);
    add("ctrl_read",      1, 0, B+32'h10, 32'h0,          4'h0, 32'h0,          0);
    add("rd_off18_fault", 1, 0, B+32'h18, 32'h0,          4'h0, 32'h0,          1);
    add("rd_off02_fault", 1, 0, B+32'h02, 32'h0,          4'h0, 32'h0,          1);
    add("wr_off1c_fault", 0, 1, B+32'h1C, 32'hFFFF_FFFF,  4'hF, 32'h0,          1);
    add("rd_outside",     1, 0, B+32'h20, 32'h0,          4'h0, 32'h0,          0);
    add("wr_outside",     0, 1, B+32'h20, 32'h0,          4'hF, 32'h0,          0);
    add("mlo_after_out",  1, 0, B+32'h00, 32'h0,          4'h0, 32'h1122_3344,  0);
    add("wr_misalign",    0, 1, B+32'h01, 32'h0,          4'hF, 32'h0,          1);
    add("mlo_after_mis",  1, 0, B+32'h00, 32'h0,          4'h0, 32'h1122_3344,  0);
    add("ctrl_mis_fault", 0, 1, B+32'h11, 32'h1,          4'hF, 32'h0,          1);
    add("ctrl_after_mis", 1, 0, B+32'h10, 32'h0,          4'h0, 32'h0,          0);
    add("ctrl_nostrb",    0, 1, B+32'h10, 32'h1,          4'h0, 32'h0,          0);
    add("ctrl_after_ns",  1, 0, B+32'h10, 32'h0,          4'h0, 32'h0,          0);
    add("cmphi_rdwr",     1, 1, B+32'h0C, 32'h1234_5678,  4'hF, 32'hFFFF_FFFF,  0);
    add("cmphi_new",      1, 0, B+32'h0C, 32'h0,          4'h0, 32'h1234_5678,  0);

    // Outputs held in reset.
    #12;
    rd_en = 1'b1; addr = B;
    #1 chk("rst_rd_data", rd_data, 32'd0);
    addr = B + 32'h2;
    #1 chk("rst_fault", {31'd0, access_fault}, 32'd0);
    chk("rst_irq", {31'd0, mtime_interrupt}, 32'd0);
    rd_en = 1'b0; addr = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // PRESCALE=3 from reset: one tick every four cycles.
    for (int k = 0; k < 9; k++) rd("presc3_mlo", B, 32'(k / 4));

    foreach (vecs[i]) begin
      bus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].s, r, f);
      chk({vecs[i].name, "_data"}, r, vecs[i].exp_rd);
      chk({vecs[i].name, "_fault"}, {31'd0, f}, {31'd0, vecs[i].exp_fault});
    end
    chk("irq_after_table", {31'd0, mtime_interrupt}, 32'd1);

    // Carry into the high half, then atomic lo/hi read across a rollover.
    wr(B+32'h14, 32'h0, 4'hF);
    wr(B+32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(B+32'h04, 32'h0, 4'hF);
    wr(B+32'h10, 32'h1, 4'h1);
    idle();
    rd("carry_lo", B+32'h00, 32'h0);
    rd("carry_hi", B+32'h04, 32'h1);
    wr(B+32'h10, 32'h0, 4'h1);
    wr(B+32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(B+32'h04, 32'h0, 4'hF);
    wr(B+32'h10, 32'h1, 4'h1);
    rd("atomic_lo", B+32'h00, 32'hFFFF_FFFF);
    rd("atomic_hi", B+32'h04, 32'h0);
    rd("atomic_lo2", B+32'h00, 32'h1);
    rd("atomic_hi2", B+32'h04, 32'h1);

    // Compare interrupt: mtime 100 counting towards mtimecmp 105.
    wr(B+32'h10, 32'h0, 4'h1);
    wr(B+32'h00, 32'd100, 4'hF);
    wr(B+32'h04, 32'h0, 4'hF);
    wr(B+32'h0C, 32'h0, 4'hF);
    wr(B+32'h08, 32'd105, 4'hF);
    idle();
    chk("irq_below", {31'd0, mtime_interrupt}, 32'd0);
    wr(B+32'h10, 32'h1, 4'h1);
    for (int k = 1; k <= 7; k++) begin
      idle();
      chk("irq_rise", {31'd0, mtime_interrupt}, (k >= 6) ? 32'd1 : 32'd0);
    end
    wr(B+32'h0C, 32'h1, 4'hF);
    chk("irq_hold_1edge", {31'd0, mtime_interrupt}, 32'd1);
    idle();
    chk("irq_drop_2edge", {31'd0, mtime_interrupt}, 32'd0);

    // Strobed MTIME_LO write in a tick cycle, then one mid-prescale.
    wr(B+32'h10, 32'h0, 4'h1);
    wr(B+32'h14, 32'd2, 4'hF);
    wr(B+32'h00, 32'h1122_3344, 4'hF);
    wr(B+32'h04, 32'h0, 4'hF);
    wr(B+32'h10, 32'h1, 4'h1);
    idle();
    idle();
    wr(B+32'h00, 32'h0000_AB00, 4'b0010);
    for (int k = 0; k < 4; k++) rd("strb_tick", B, (k < 3) ? 32'h1122_AB44 : 32'h1122_AB45);
    wr(B+32'h00, 32'h0000_00FF, 4'b0001);
    for (int k = 0; k < 4; k++) rd("strb_pclr", B, (k < 3) ? 32'h1122_ABFF : 32'h1122_AC00);
    rd("strb_hi", B+32'h04, 32'h0);

    // Asynchronous reset between edges with the interrupt high.
    wr(B+32'h0C, 32'h0, 4'hF);
    wr(B+32'h08, 32'h0, 4'hF);
    idle();
    idle();
    chk("irq_pre_reset", {31'd0, mtime_interrupt}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_irq", {31'd0, mtime_interrupt}, 32'd0);
    rd_en = 1'b1; addr = B + 32'h08;
    #1 chk("async_rd_data", rd_data, 32'd0);
    rd_en = 1'b0; addr = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd("post_mlo", B+32'h00, 32'h0);
    rd("post_mhi", B+32'h04, 32'h0);
    rd("post_cmplo", B+32'h08, 32'hFFFF_FFFF);
    rd("post_cmphi", B+32'h0C, 32'hFFFF_FFFF);
    rd("post_ctrl", B+32'h10, 32'h1);
    rd("post_presc", B+32'h14, 32'h3);
    rd("post_mlo_tick", B+32'h00, 32'h1);
    chk("post_irq", {31'd0, mtime_interrupt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
